// File: rtl/mult_pkg.sv
// Shared types and widths for the Booth multiplier and its issue/collect controller.
package mult_pkg;

    localparam int MULT_LATENCY = 3;
    localparam int MULT_W       = 32;
    localparam int PROD_W       = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // The one-deep output slot can take new data if empty or being drained this cycle.
    function automatic logic out_free(input logic valid, input logic ready);
        return (~valid) | ready;
    endfunction

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Operand (s_*) and result (m_*) handshakes of the multiplier issue controller.
interface mult_issue_ctrl_if
    import mult_pkg::*;
#(
    parameter int TAG_W = 4
);
    logic              s_valid;
    logic              s_ready;
    logic [MULT_W-1:0] s_a;
    logic [MULT_W-1:0] s_b;
    logic [TAG_W-1:0]  s_tag;
    logic              m_valid;
    logic              m_ready;
    logic [PROD_W-1:0] m_result;
    logic [TAG_W-1:0]  m_tag;

    modport master (
        output s_valid, s_a, s_b, s_tag, m_ready,
        input  s_ready, m_valid, m_result, m_tag
    );

    modport slave (
        input  s_valid, s_a, s_b, s_tag, m_ready,
        output s_ready, m_valid, m_result, m_tag
    );
endinterface

// File: rtl/mult_out_reg.sv
// One-deep valid/ready output register; a load wins over a consume on the same edge.
module mult_out_reg
    import mult_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag,
    output logic              free
);
    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [TAG_W-1:0]  tag_r;

    assign free  = out_free(valid_r, ready);
    assign valid = valid_r;
    assign data  = data_r;
    assign tag   = tag_r;

    // Load/consume of the result slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
            tag_r   <= {TAG_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            tag_r   <= load_tag;
        end else if (ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end
endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/collect controller for the pipelined Booth multiplier.
// Optional perf counters (perf_ops, perf_stall) under `MULT_ISSUE_PERF_EN.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int LATENCY = MULT_LATENCY,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    mult_issue_ctrl_if.slave  io,
    output logic [MULT_W-1:0] mul_in0,
    output logic [MULT_W-1:0] mul_in1,
    input  logic [PROD_W-1:0] mul_result,
    output logic              busy
`ifdef MULT_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [MULT_W-1:0] in0_r;
    logic [MULT_W-1:0] in1_r;
    logic [TAG_W-1:0]  op_tag_r;
    logic              ready_r;
    logic              busy_r;
    logic              free_s;
    logic              capture_s;
    logic              out_valid_s;
    logic [PROD_W-1:0] out_data_s;
    logic [TAG_W-1:0]  out_tag_s;

    assign io.s_ready  = ready_r;
    assign busy        = busy_r;
    assign mul_in0     = in0_r;
    assign mul_in1     = in1_r;
    assign io.m_valid  = out_valid_s;
    assign io.m_result = out_data_s;
    assign io.m_tag    = out_tag_s;

    // Product is captured when it is due and the result slot can take it.
    always_comb begin
        capture_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if ((cnt_r == LAT_C) && free_s) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (free_s) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end
            default: capture_s = 1'b0;
        endcase
    end

    // Control FSM; operands stay latched from acceptance until capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            in0_r    <= {MULT_W{1'b0}};
            in1_r    <= {MULT_W{1'b0}};
            op_tag_r <= {TAG_W{1'b0}};
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (io.s_valid) begin
                        in0_r    <= io.s_a;
                        in1_r    <= io.s_b;
                        op_tag_r <= io.s_tag;
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= ST_RUN;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAT_C) begin
                        if (free_s) begin
                            state_r <= ST_IDLE;
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (free_s) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    mult_out_reg #(
        .DATA_W (PROD_W),
        .TAG_W  (TAG_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (capture_s),
        .load_data (mul_result),
        .load_tag  (op_tag_r),
        .ready     (io.m_ready),
        .valid     (out_valid_s),
        .data      (out_data_s),
        .tag       (out_tag_s),
        .free      (free_s)
    );

`ifdef MULT_ISSUE_PERF_EN
    logic [31:0] perf_ops_r;
    logic [31:0] perf_stall_r;

    assign perf_ops   = perf_ops_r;
    assign perf_stall = perf_stall_r;

    // Capture and HOLD-cycle counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_r   <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (capture_s) begin
                perf_ops_r <= perf_ops_r + 32'd1;
            end else begin
                perf_ops_r <= perf_ops_r;
            end
            if (state_r == ST_HOLD) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Randomized + directed bench for mult_issue_ctrl against a transaction-level model.
module tb_mult_issue_ctrl;
    localparam int LAT = 3;
    localparam int TW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mul_in0, mul_in1;
    logic [63:0] mul_result;
    logic        busy;
    logic [63:0] pipe [LAT];
`ifdef MULT_ISSUE_PERF_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    mult_issue_ctrl_if #(.TAG_W(TW)) bus ();

    mult_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (bus),
        .mul_in0    (mul_in0),
        .mul_in1    (mul_in1),
        .mul_result (mul_result),
        .busy       (busy)
`ifdef MULT_ISSUE_PERF_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: LAT-stage registered product of its inputs.
    always @(posedge clk) begin
        pipe[0] <= 64'(mul_in0) * 64'(mul_in1);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_result = pipe[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: an op in flight of a given age, plus a one-slot result buffer.
    bit          m_busy;
    int          m_age;
    logic [31:0] m_a, m_b;
    logic [TW-1:0] m_optag;
    bit          m_ev;
    logic [63:0] m_res;
    logic [TW-1:0] m_tag;
    int          m_ops, m_stall;
    bit          accepted;
    bit          consumed;
    logic [TW-1:0] consumed_tag;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit free;
        accepted = 1'b0;
        consumed = m_ev && bus.m_ready && !rst;
        consumed_tag = bus.m_tag;
        if (rst) begin
            m_busy = 0; m_age = 0; m_a = '0; m_b = '0; m_optag = '0;
            m_ev = 0; m_res = '0; m_tag = '0; m_ops = 0; m_stall = 0;
        end else begin
            free = !m_ev || bus.m_ready;
            if (!m_busy) begin
                if (m_ev && bus.m_ready) m_ev = 0;
                if (bus.s_valid) begin
                    m_busy = 1; m_age = 0; accepted = 1'b1;
                    m_a = bus.s_a; m_b = bus.s_b; m_optag = bus.s_tag;
                end
            end else if (m_age >= LAT && free) begin
                if (m_age > LAT) m_stall++;
                m_ev = 1; m_res = 64'(m_a) * 64'(m_b); m_tag = m_optag;
                m_busy = 0; m_ops++;
            end else begin
                if (m_age > LAT) m_stall++;
                if (m_ev && bus.m_ready) m_ev = 0;
                m_age++;
            end
        end
    endtask

    // One clock: model advances on the edge, DUT is compared at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        chk("s_ready", 64'(bus.s_ready), 64'(!m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("m_valid", 64'(bus.m_valid), 64'(m_ev));
        chk("mul_in0", 64'(mul_in0), 64'(m_a));
        chk("mul_in1", 64'(mul_in1), 64'(m_b));
        if (m_ev) begin
            chk("m_result", bus.m_result, m_res);
            chk("m_tag", 64'(bus.m_tag), 64'(m_tag));
        end
`ifdef MULT_ISSUE_PERF_EN
        chk("perf_ops", 64'(perf_ops), 64'(m_ops));
        chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.s_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
        bus.s_valid = 1'b1; bus.s_a = a; bus.s_b = b; bus.s_tag = t;
        step();
        bus.s_valid = 1'b0;
    endtask

    initial begin
        int last_acc;
        int n_acc;
        int n_seen;
        int guard;
        bit pend;
        logic [TW-1:0] exp_tags [4];
        logic [TW-1:0] got_tags [$];

        rst = 1'b1; bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_tag = '0;
        bus.m_ready = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        chk("rst_m_result", bus.m_result, 64'h0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'h1);

        // 7*6 tag 3: result exactly LAT+1 cycles after the accept edge.
        offer(32'd7, 32'd6, 4'd3);
        repeat (3) step();
        chk("lat_not_yet", 64'(bus.m_valid), 64'h0);
        step();
        chk("lat_valid", 64'(bus.m_valid), 64'h1);
        chk("lat_result", bus.m_result, 64'd42);
        chk("lat_tag", 64'(bus.m_tag), 64'd3);
        chk("lat_s_ready", 64'(bus.s_ready), 64'h1);
        step();

        offer(32'h0000_FFFF, 32'h0001_0000, 4'd9);
        repeat (4) step();
        chk("wide_result", bus.m_result, 64'h0000_0000_FFFF_0000);
        step();

        // Backpressure: second op completes while first result is unconsumed.
        do_reset();
        bus.m_ready = 1'b0;
        offer(32'd7, 32'd6, 4'd3);
        repeat (4) step();
        offer(32'd5, 32'd5, 4'd1);
        repeat (4) step();
        repeat (3) step();
        chk("bp_busy", 64'(busy), 64'h1);
        chk("bp_in0", 64'(mul_in0), 64'd5);
        chk("bp_in1", 64'(mul_in1), 64'd5);
        chk("bp_old", bus.m_result, 64'd42);
        bus.m_ready = 1'b1;
        step();
        chk("bp_valid", 64'(bus.m_valid), 64'h1);
        chk("bp_new", bus.m_result, 64'd25);
        chk("bp_tag", 64'(bus.m_tag), 64'd1);
`ifdef MULT_ISSUE_PERF_EN
        chk("bp_perf_ops", 64'(perf_ops), 64'd2);
        chk("bp_perf_stall_lit", 64'(perf_stall), 64'd4);
`endif
        step();

        // Reset two cycles into RUN.
        offer(32'd11, 32'd13, 4'd2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(bus.m_valid), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_ready", 64'(bus.s_ready), 64'h1);
        chk("mid_rst_in0", 64'(mul_in0), 64'h0);
        repeat (6) step();
        chk("mid_rst_no_stale", 64'(bus.m_valid), 64'h0);

        // Continuous s_valid: accepts LAT+2 apart, results in order.
        exp_tags[0] = 4'd4; exp_tags[1] = 4'd5; exp_tags[2] = 4'd6; exp_tags[3] = 4'd7;
        bus.m_ready = 1'b1; n_acc = 0; last_acc = 0; guard = 0;
        bus.s_valid = 1'b1; bus.s_a = 32'd1; bus.s_b = 32'd10; bus.s_tag = exp_tags[0];
        while (got_tags.size() < 4 && guard < 60) begin
            step();
            guard++;
            if (consumed) got_tags.push_back(consumed_tag);
            if (accepted) begin
                if (n_acc > 0) chk("accept_gap", 64'(cyc - last_acc), 64'(LAT + 2));
                last_acc = cyc;
                n_acc++;
                if (n_acc < 4) begin
                    bus.s_a = 32'(n_acc + 1); bus.s_b = 32'(n_acc + 10);
                    bus.s_tag = exp_tags[n_acc];
                end else begin
                    bus.s_valid = 1'b0;
                end
            end
        end
        if (bus.m_valid) begin
            step();
            if (consumed) got_tags.push_back(consumed_tag);
        end
        chk("stream_count", 64'(got_tags.size()), 64'd4);
        n_seen = got_tags.size();
        for (int i = 0; i < 4 && i < n_seen; i++) chk("stream_tag", 64'(got_tags[i]), 64'(exp_tags[i]));

        // Random traffic with backpressure and occasional reset.
        pend = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (!pend) begin
                bus.s_valid = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 3))
                    0: bus.s_a = 32'hFFFF_FFFF;
                    1: bus.s_a = 32'h0;
                    default: bus.s_a = $urandom;
                endcase
                bus.s_b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                bus.s_tag = TW'($urandom);
                pend = bus.s_valid;
            end
            bus.m_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
            if (accepted || rst) pend = 1'b0;
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
